// File: rtl/mem_arb_pkg.sv
// Shared encodings for the IFU/LSU memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    localparam logic [1:0] LEN_B = 2'b00;
    localparam logic [1:0] LEN_H = 2'b01;
    localparam logic [1:0] LEN_W = 2'b10;

    // 2'b11 is not a real size; downstream only ever sees B/H/W.
    function automatic logic [1:0] norm_len(input logic [1:0] len);
        return (len == 2'b11) ? LEN_W : len;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; bit 0 = IFU, bit 1 = LSU. Pointer lives in the parent.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_grant,
    output logic [1:0] gnt
);

    assign gnt[0] = req[0] & (~req[1] | (last_grant == OWN_LSU));
    assign gnt[1] = req[1] & (~req[0] | (last_grant == OWN_IFU));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one downstream memory port between IFU fetches and LSU loads/stores,
// one transaction at a time, with a timeout that turns a lost response into an error.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    input  logic              ifu_resp_ready,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_resp_err,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [1:0]        lsu_len,
    output logic              lsu_resp_valid,
    input  logic              lsu_resp_ready,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_resp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_len,
    input  logic              mem_resp_valid,
    output logic              mem_resp_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t            state;
    owner_t            owner;
    owner_t            last_grant;
    logic              stale;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        len_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic [1:0] gnt;
    logic       idle;
    logic       timeout_hit;
    logic       owner_take;

    rr_arb2 u_rr (
        .req        ({lsu_req_valid, ifu_req_valid}),
        .last_grant (last_grant),
        .gnt        (gnt)
    );

    assign idle          = (state == S_IDLE);
    assign ifu_req_ready = idle & gnt[0] & ~rst;
    assign lsu_req_ready = idle & gnt[1] & ~rst;

    // A stale response from a timed-out access must drain before anything new goes out.
    assign mem_req_valid  = (state == S_REQ) & ~stale;
    assign mem_resp_ready = (state == S_WAIT) | stale;
    assign mem_addr       = addr_q;
    assign mem_wen        = wen_q;
    assign mem_wdata      = wdata_q;
    assign mem_len        = len_q;

    assign ifu_resp_valid = (state == S_RESP) & (owner == OWN_IFU);
    assign lsu_resp_valid = (state == S_RESP) & (owner == OWN_LSU);
    assign ifu_rdata      = (owner == OWN_IFU) ? rdata_q : '0;
    assign lsu_rdata      = (owner == OWN_LSU) ? rdata_q : '0;
    assign ifu_resp_err   = (owner == OWN_IFU) & err_q;
    assign lsu_resp_err   = (owner == OWN_LSU) & err_q;

    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);
    assign owner_take  = (owner == OWN_IFU) ? ifu_resp_ready : lsu_resp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            owner      <= OWN_IFU;
            last_grant <= OWN_LSU;
            stale      <= 1'b0;
            cnt        <= '0;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            len_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            if (stale && mem_resp_valid)
                stale <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ifu_req_valid && ifu_req_ready) begin
                        owner   <= OWN_IFU;
                        addr_q  <= ifu_addr;
                        wen_q   <= 1'b0;
                        wdata_q <= '0;
                        len_q   <= LEN_W;
                        cnt     <= '0;
                        state   <= S_REQ;
                    end else if (lsu_req_valid && lsu_req_ready) begin
                        owner   <= OWN_LSU;
                        addr_q  <= lsu_addr;
                        wen_q   <= lsu_wen;
                        wdata_q <= lsu_wdata;
                        len_q   <= norm_len(lsu_len);
                        cnt     <= '0;
                        state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    cnt <= cnt + 1'b1;
                    if (mem_req_valid && mem_req_ready) begin
                        state <= S_WAIT;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        state   <= S_RESP;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (mem_resp_valid) begin
                        rdata_q <= wen_q ? '0 : mem_rdata;
                        err_q   <= 1'b0;
                        state   <= S_RESP;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        stale   <= 1'b1;
                        state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (owner_take) begin
                        last_grant <= owner;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a small responding memory model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    typedef struct packed {
        logic        own;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        ifu_req_valid = 0, ifu_req_ready, ifu_resp_valid, ifu_resp_ready = 0, ifu_resp_err;
    logic [31:0] ifu_addr = 0, ifu_rdata;
    logic        lsu_req_valid = 0, lsu_req_ready, lsu_wen = 0, lsu_resp_valid, lsu_resp_ready = 0, lsu_resp_err;
    logic [31:0] lsu_addr = 0, lsu_wdata = 0, lsu_rdata;
    logic [1:0]  lsu_len = 0;
    logic        mem_req_valid, mem_req_ready = 1, mem_wen, mem_resp_ready;
    logic        mem_resp_valid = 0;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 0;
    logic [1:0]  mem_len;

    int    vectors = 0;
    int    miscompares = 0;
    resp_t exp_q[$];

    logic        mem_mute = 0;
    logic [31:0] mem_data_next = 0;
    int          inj_req = 0, inj_ack = 0;
    logic [31:0] m_addr = 0, m_wdata = 0;
    logic        m_wen = 0;
    logic [1:0]  m_len = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .CNT_W(9)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
        .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_len(lsu_len),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
        .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_len(mem_len),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata)
    );

    // Zero-wait memory: answers one cycle after accepting a request unless muted.
    always @(posedge clk) begin
        if (rst) begin
            mem_resp_valid <= 1'b0;
        end else begin
            if (mem_resp_valid && mem_resp_ready)
                mem_resp_valid <= 1'b0;
            if (mem_req_valid && mem_req_ready) begin
                m_addr  <= mem_addr;
                m_wen   <= mem_wen;
                m_wdata <= mem_wdata;
                m_len   <= mem_len;
                if (!mem_mute) begin
                    mem_resp_valid <= 1'b1;
                    mem_rdata      <= mem_data_next;
                end
            end else if (inj_req != inj_ack) begin
                mem_resp_valid <= 1'b1;
                mem_rdata      <= 32'hDEADBEEF;
                inj_ack        <= inj_req;
            end
        end
    end

    task automatic drive_req(input logic lsu, input logic [31:0] a, input logic w,
                             input logic [31:0] d, input logic [1:0] l);
        if (lsu) begin
            lsu_req_valid = 1; lsu_addr = a; lsu_wen = w; lsu_wdata = d; lsu_len = l;
        end else begin
            ifu_req_valid = 1; ifu_addr = a;
        end
        #1;
        for (int n = 0; n < 50; n++) begin
            if (lsu ? lsu_req_ready : ifu_req_ready) begin
                @(posedge clk); #1;
                if (lsu) lsu_req_valid = 0; else ifu_req_valid = 0;
                return;
            end
            @(negedge clk); #1;
        end
        vectors++; miscompares++;
        $display("FAIL grant_timeout: requester %0d got no ready in 50 cycles", lsu);
        lsu_req_valid = 0; ifu_req_valid = 0;
    endtask

    task automatic wait_resp(output resp_t got, output int lat);
        got = '0; lat = 0;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (ifu_resp_valid || lsu_resp_valid) begin
                got = lsu_resp_valid ? {1'b1, lsu_rdata, lsu_resp_err} : {1'b0, ifu_rdata, ifu_resp_err};
                lat = n;
                return;
            end
        end
        vectors++; miscompares++;
        $display("FAIL resp_timeout: no response valid within 50 cycles");
    endtask

    task automatic take_resp();
        if (lsu_resp_valid) lsu_resp_ready = 1; else ifu_resp_ready = 1;
        @(posedge clk); #1;
        lsu_resp_ready = 0; ifu_resp_ready = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if ({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_req_valid, mem_resp_ready,
             ifu_rdata, ifu_resp_err, lsu_rdata, lsu_resp_err, mem_addr, mem_wen, mem_wdata, mem_len} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: some output nonzero during reset (mem_addr=%h mrv=%b)", mem_addr, mem_req_valid);
        end
        rst = 0;
        @(negedge clk);
        vectors++;
        if ({ifu_req_ready, lsu_req_ready, mem_req_valid, mem_resp_ready} !== 4'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got %b want 0000",
                     {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_resp_ready});
        end
    endtask

    task automatic test_ifu_fetch();
        resp_t got, exp;
        int lat;
        mem_data_next = 32'h00000413;
        exp_q.push_back(resp_t'{own: 1'b0, rdata: 32'h00000413, err: 1'b0});
        drive_req(1'b0, 32'h80000000, 1'b0, 32'h0, 2'b00);
        wait_resp(got, lat);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL ifu_fetch_resp: got %h want %h", got, exp); end
        vectors++;
        if (lat != 3) begin miscompares++; $display("FAIL ifu_fetch_latency: got %0d want 3", lat); end
        vectors++;
        if ({m_addr, m_wen, m_len} !== {32'h80000000, 1'b0, 2'b10}) begin
            miscompares++;
            $display("FAIL ifu_fetch_mreq: got addr=%h wen=%b len=%b want 80000000/0/10", m_addr, m_wen, m_len);
        end
        take_resp();
    endtask

    task automatic test_tie();
        resp_t got, exp;
        int lat;
        logic who;
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        ifu_addr = 32'h80000100; lsu_addr = 32'h80002000; lsu_wen = 0; lsu_len = 2'b10;
        ifu_req_valid = 1; lsu_req_valid = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            for (int n = 0; n < 20 && !(ifu_req_ready || lsu_req_ready); n++) begin @(negedge clk); #1; end
            who = lsu_req_ready;
            vectors++;
            if (!(ifu_req_ready || lsu_req_ready) || who !== logic'(i % 2)) begin
                miscompares++;
                $display("FAIL tie_grant_%0d: got ifu_rdy=%b lsu_rdy=%b want owner %0d", i, ifu_req_ready, lsu_req_ready, i % 2);
            end
            mem_data_next = 32'h1000 + i;
            exp_q.push_back(resp_t'{own: logic'(i % 2), rdata: 32'h1000 + i, err: 1'b0});
            @(posedge clk);
            wait_resp(got, lat);
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin miscompares++; $display("FAIL tie_resp_%0d: got %h want %h", i, got, exp); end
            take_resp();
        end
        ifu_req_valid = 0; lsu_req_valid = 0;
        @(negedge clk);
    endtask

    task automatic test_store();
        logic [31:0] t_addr[3]  = '{32'h80001000, 32'h80001002, 32'h80001004};
        logic        t_wen[3]   = '{1'b1, 1'b0, 1'b0};
        logic [31:0] t_wdata[3] = '{32'h12345678, 32'h0, 32'h0};
        logic [1:0]  t_len[3]   = '{2'b00, 2'b01, 2'b11};
        logic [1:0]  t_mlen[3]  = '{2'b00, 2'b01, 2'b10};
        logic [31:0] t_mem[3]   = '{32'hFFFFFFFF, 32'h0000BEEF, 32'hA5A55A5A};
        logic [31:0] t_rd[3]    = '{32'h0, 32'h0000BEEF, 32'hA5A55A5A};
        resp_t got, exp;
        int lat;
        for (int i = 0; i < 3; i++) begin
            mem_data_next = t_mem[i];
            exp_q.push_back(resp_t'{own: 1'b1, rdata: t_rd[i], err: 1'b0});
            drive_req(1'b1, t_addr[i], t_wen[i], t_wdata[i], t_len[i]);
            wait_resp(got, lat);
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin miscompares++; $display("FAIL lsu_resp_%0d: got %h want %h", i, got, exp); end
            vectors++;
            if ({m_addr, m_wen, m_wdata, m_len} !== {t_addr[i], t_wen[i], t_wdata[i], t_mlen[i]}) begin
                miscompares++;
                $display("FAIL lsu_mreq_%0d: got %h/%b/%h/%b want %h/%b/%h/%b", i, m_addr, m_wen, m_wdata, m_len,
                         t_addr[i], t_wen[i], t_wdata[i], t_mlen[i]);
            end
            take_resp();
        end
    endtask

    task automatic test_timeout();
        resp_t got, exp;
        int lat;
        mem_mute = 1;
        exp_q.push_back(resp_t'{own: 1'b1, rdata: 32'h0, err: 1'b1});
        drive_req(1'b1, 32'h80004000, 1'b0, 32'h0, 2'b10);
        wait_resp(got, lat);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL timeout_resp: got %h want %h", got, exp); end
        vectors++;
        if (lat != 9) begin miscompares++; $display("FAIL timeout_latency: got %0d want 9", lat); end
        vectors++;
        if (mem_resp_ready !== 1'b1) begin miscompares++; $display("FAIL stale_drain_ready: got %b want 1", mem_resp_ready); end
        take_resp();
        mem_mute = 0;
        mem_data_next = 32'h00000055;
        exp_q.push_back(resp_t'{own: 1'b0, rdata: 32'h00000055, err: 1'b0});
        drive_req(1'b0, 32'h80000010, 1'b0, 32'h0, 2'b00);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++;
            if ({mem_req_valid, mem_resp_ready} !== 2'b01) begin
                miscompares++;
                $display("FAIL stale_hold_%0d: got req_v=%b resp_r=%b want 0/1", i, mem_req_valid, mem_resp_ready);
            end
        end
        inj_req++;
        wait_resp(got, lat);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL after_stale_resp: got %h want %h", got, exp); end
        take_resp();
        @(negedge clk);
        vectors++;
        if (mem_resp_ready !== 1'b0) begin miscompares++; $display("FAIL stale_cleared: got %b want 0", mem_resp_ready); end
    endtask

    task automatic test_back_to_back();
        resp_t got, exp;
        int lat;
        mem_data_next = 32'hCAFEF00D;
        exp_q.push_back(resp_t'{own: 1'b1, rdata: 32'hCAFEF00D, err: 1'b0});
        drive_req(1'b1, 32'h80003000, 1'b0, 32'h0, 2'b10);
        wait_resp(got, lat);
        ifu_addr = 32'h80000200; ifu_req_valid = 1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            vectors++;
            if ({lsu_resp_valid, lsu_rdata, ifu_req_ready, ifu_resp_valid} !== {1'b1, 32'hCAFEF00D, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL hold_resp_%0d: got v=%b d=%h ifu_rdy=%b want 1/cafef00d/0", i, lsu_resp_valid, lsu_rdata, ifu_req_ready);
            end
        end
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL held_resp: got %h want %h", got, exp); end
        take_resp();
        mem_data_next = 32'h0BADC0DE;
        exp_q.push_back(resp_t'{own: 1'b0, rdata: 32'h0BADC0DE, err: 1'b0});
        drive_req(1'b0, 32'h80000200, 1'b0, 32'h0, 2'b00);
        wait_resp(got, lat);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL after_hold_resp: got %h want %h", got, exp); end
        take_resp();
    endtask

    task automatic test_reset_mid();
        resp_t got, exp;
        int lat;
        mem_mute = 1;
        drive_req(1'b0, 32'h80000040, 1'b0, 32'h0, 2'b00);
        @(negedge clk); @(negedge clk);
        #2 rst = 1;
        #1;
        vectors++;
        if ({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_req_valid, mem_resp_ready,
             ifu_rdata, ifu_resp_err, lsu_rdata, lsu_resp_err, mem_addr, mem_wen, mem_wdata, mem_len} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: outputs nonzero, mem_addr=%h mem_resp_ready=%b", mem_addr, mem_resp_ready);
        end
        @(negedge clk); rst = 0; mem_mute = 0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({ifu_resp_valid, lsu_resp_valid, mem_req_valid} !== 3'b0) begin
            miscompares++;
            $display("FAIL aborted_silent: got %b want 000", {ifu_resp_valid, lsu_resp_valid, mem_req_valid});
        end
        mem_data_next = 32'h00100073;
        exp_q.push_back(resp_t'{own: 1'b0, rdata: 32'h00100073, err: 1'b0});
        drive_req(1'b0, 32'h80000000, 1'b0, 32'h0, 2'b00);
        wait_resp(got, lat);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL post_reset_fetch: got %h want %h", got, exp); end
        take_resp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ifu_fetch();
        test_tie();
        test_store();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
